// File: rtl/data_ram_sb.sv
// data_ram_sb: word-addressed data RAM with byte-lane writes, an optional posted store buffer and load forwarding (store buffer built when DATA_RAM_SB_EN is defined)
module data_ram_sb #(
  parameter int DEPTH_AW = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce_i,
  input  logic                        we_i,
  input  logic [31:0]                 addr_i,
  input  logic [3:0]                  sel_i,
  input  logic [31:0]                 data_i,
  output logic [31:0]                 data_o,
  output logic [$clog2(SB_DEPTH):0]   sb_count_o,
  output logic                        sb_empty_o
);
  localparam int PW = $clog2(SB_DEPTH);
  logic [31:0]         mem_q [2**DEPTH_AW];
  logic [DEPTH_AW-1:0] idx, wr_idx;
  logic                load, store, wr_en, unused_ok;
  logic [3:0]          wr_sel;
  logic [31:0]         wr_data, rdata;
  assign idx       = addr_i[DEPTH_AW+1:2];
  assign load      = ce_i & ~we_i;
  assign store     = ce_i & we_i & |sel_i;
  assign unused_ok = ^{addr_i[31:DEPTH_AW+2], addr_i[1:0]};
`ifdef DATA_RAM_SB_EN
  logic [DEPTH_AW-1:0] sb_idx_q  [SB_DEPTH];
  logic [3:0]          sb_sel_q  [SB_DEPTH];
  logic [31:0]         sb_data_q [SB_DEPTH];
  logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic                retire;
  // oldest entry retires whenever a load does not own the array port; a full buffer retires and enqueues together
  always_comb begin
    retire  = ~load & (cnt_q != '0);
    rd_d    = rd_q + PW'(retire);
    wr_d    = wr_q + PW'(store);
    cnt_d   = cnt_q + (PW+1)'(store) - (PW+1)'(retire);
    wr_en   = rst & retire;
    wr_idx  = sb_idx_q[rd_q];
    wr_sel  = sb_sel_q[rd_q];
    wr_data = sb_data_q[rd_q];
  end
  // load data: array word overlaid by matching buffered stores, oldest first so the newest lane wins
  always_comb begin
    rdata = mem_q[idx];
    for (int i = 0; i < SB_DEPTH; i++)
      if ((PW+1)'(i) < cnt_q && sb_idx_q[rd_q + PW'(i)] == idx)
        for (int b = 0; b < 4; b++)
          if (sb_sel_q[rd_q + PW'(i)][b]) rdata[8*b +: 8] = sb_data_q[rd_q + PW'(i)][8*b +: 8];
  end
  // buffer pointers and occupancy; reset discards unretired stores
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // enqueue posted stores at the write pointer
  always_ff @(posedge clk) begin
    if (rst && store) begin
      sb_idx_q[wr_q]  <= idx;
      sb_sel_q[wr_q]  <= sel_i;
      sb_data_q[wr_q] <= data_i;
    end
  end
  assign sb_count_o = cnt_q;
  assign sb_empty_o = ~rst | (cnt_q == '0);
`else
  // without a buffer, stores go straight into the array and loads read it directly
  always_comb begin
    wr_en   = rst & store;
    wr_idx  = idx;
    wr_sel  = sel_i;
    wr_data = data_i;
    rdata   = mem_q[idx];
  end
  assign sb_count_o = '0;
  assign sb_empty_o = 1'b1;
`endif
  assign data_o = (rst & load) ? rdata : '0;
  // byte-lane array write; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_sel[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
  end
endmodule

// File: tb/tb_data_ram_sb.sv
// tb_data_ram_sb: randomized and directed checks of data_ram_sb against a queue-based reference model
module tb_data_ram_sb;
  logic        clk = 0, rst = 0, ce_i = 0, we_i = 0;
  logic [31:0] addr_i = 0, data_i = 0, data_o, obs;
  logic [3:0]  sel_i = 0;
  logic [2:0]  sb_count_o;
  logic        sb_empty_o;
  int vectors = 0, miscompares = 0;

  typedef struct { logic [9:0] idx; logic [3:0] sel; logic [31:0] data; } ent_t;
  ent_t        q[$];
  logic [31:0] m [1024];

  data_ram_sb #(.DEPTH_AW(10), .SB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i),
    .data_i(data_i), .data_o(data_o), .sb_count_o(sb_count_o), .sb_empty_o(sb_empty_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic step(input logic r, input logic c, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    logic [31:0] exp_d;
    logic [9:0]  ix = a[11:2];
    logic        ld = c & ~w, st = c & w & |s;
    @(negedge clk);
    rst = r; ce_i = c; we_i = w; addr_i = a; sel_i = s; data_i = d;
    #1;
    exp_d = m[ix];
    foreach (q[i]) if (q[i].idx == ix) exp_d = merge(exp_d, q[i].data, q[i].sel);
    if (!(r && ld)) exp_d = 0;
    obs = data_o;
    chk("data_o", data_o, exp_d);
`ifdef DATA_RAM_SB_EN
    chk("sb_count", 32'(sb_count_o), 32'(q.size()));
    chk("sb_empty", 32'(sb_empty_o), 32'(!r || q.size() == 0));
`else
    chk("sb_count", 32'(sb_count_o), 0);
    chk("sb_empty", 32'(sb_empty_o), 1);
`endif
    @(posedge clk);
`ifdef DATA_RAM_SB_EN
    if (!r) q.delete();
    else begin
      if (!ld && q.size() != 0) begin
        m[q[0].idx] = merge(m[q[0].idx], q[0].data, q[0].sel);
        void'(q.pop_front());
      end
      if (st) q.push_back('{ix, s, d});
    end
`else
    if (r && st) m[ix] = merge(m[ix], d, s);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] a;
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h100, 4'hF, 0);
    for (int i = 0; i < 32; i++) step(1, 1, 1, i * 4, 4'hF, $urandom);
    step(1, 1, 1, 32'h100, 4'hF, $urandom);
    idle(5);
    // full-word store then load
    step(1, 1, 1, 32'h100, 4'hF, 32'hDEADBEEF);
    step(1, 1, 0, 32'h100, 4'hF, 0);
    chk("full_word", obs, 32'hDEADBEEF);
    idle(2);
    // byte-lane merge
    step(1, 1, 1, 32'h40, 4'hF, 32'h11223344);
    idle(2);
    step(1, 1, 1, 32'h40, 4'b0101, 32'hAABBCCDD);
    step(1, 1, 0, 32'h40, 4'hF, 0);
    chk("lane_merge", obs, 32'h11BB33DD);
    // newest store wins
    step(1, 1, 1, 32'h8, 4'b0001, 32'h000000A1);
    step(1, 1, 0, 32'h8, 4'hF, 0);
    step(1, 1, 1, 32'h8, 4'b0001, 32'h000000B2);
    step(1, 1, 0, 32'h8, 4'hF, 0);
    chk("newest_fwd", 32'(obs[7:0]), 32'hB2);
    idle(4);
    step(1, 1, 0, 32'h8, 4'hF, 0);
    chk("newest_arr", 32'(obs[7:0]), 32'hB2);
    // store burst, load stream, one more store, then read back all five
    for (int i = 0; i < 4; i++) step(1, 1, 1, 32'h60 + i * 4, 4'hF, 32'hC0DE0000 + i);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h60 + (i % 4) * 4, 4'hF, 0);
    step(1, 1, 1, 32'h70, 4'hF, 32'hC0DE0004);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 32'h60 + i * 4, 4'hF, 0);
    chk("burst_last", obs, 32'hC0DE0004);
    idle(5);
    // reset mid-operation
    step(1, 1, 1, 32'h0, 4'hF, 32'h01010101);
    step(1, 1, 1, 32'h4, 4'hF, 32'h02020202);
    step(1, 1, 1, 32'h8, 4'hF, 32'h03030303);
    step(0, 1, 0, 32'h8, 4'hF, 0);
    chk("rst_data", obs, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, i * 4, 4'hF, 0);
    // sel=0000 store ignored, aliased address wraps
    step(1, 1, 1, 32'h10, 4'h0, 32'hFFFFFFFF);
    step(1, 1, 1, 32'h1010, 4'hF, 32'h5A5A1234);
    step(1, 1, 0, 32'h10, 4'hF, 0);
    chk("wrap", obs, 32'h5A5A1234);
    // randomized traffic over a small aliased word set
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(31)) << 2);
      step($urandom_range(99) != 0, $urandom_range(3) != 0, 1'($urandom_range(1)), a,
           4'($urandom_range(15)), $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
